// File: rtl/os_generator.sv
// Ordered-set generator: emits one TS1/TS2/SKP/EIOS/IDLE set as PIPEWIDTH-wide beats.
// Outputs decode directly from state, so an asynchronous reset clears them immediately.

module osSymbolEncoder #(
  parameter logic [7:0] NFTS = 8'hFF
) (
  input  logic       active,
  input  logic [2:0] osType,
  input  logic [3:0] symIdx,
  input  logic [7:0] linkNumber,
  input  logic [1:0] laneNumber,
  input  logic [7:0] rateId,
  input  logic       loopback,
  output logic [7:0] symData,
  output logic       symK
);
  localparam logic [2:0] OS_TS1  = 3'd0;
  localparam logic [2:0] OS_TS2  = 3'd1;
  localparam logic [2:0] OS_SKP  = 3'd2;
  localparam logic [2:0] OS_EIOS = 3'd3;

  always_comb begin
    symData = 8'h00;
    symK    = 1'b0;
    if (active) begin
      case (osType)
        OS_TS1, OS_TS2: begin
          case (symIdx)
            4'd0: begin symData = 8'hBC; symK = 1'b1; end
            4'd1: symData = linkNumber;
            4'd2: symData = {6'b0, laneNumber};
            4'd3: symData = NFTS;
            4'd4: symData = rateId;
            4'd5: symData = {5'b0, loopback, 2'b0};
            default: symData = (osType == OS_TS1) ? 8'h4A : 8'h45;
          endcase
        end
        OS_SKP: begin
          symData = (symIdx == 4'd0) ? 8'hBC : 8'h1C;
          symK    = 1'b1;
        end
        OS_EIOS: begin
          symData = (symIdx == 4'd0) ? 8'hBC : 8'h7C;
          symK    = 1'b1;
        end
        default: begin
          symData = 8'h00;
          symK    = 1'b0;
        end
      endcase
    end
  end
endmodule

module os_generator #(
  parameter int         PIPEWIDTH = 8,
  parameter logic [7:0] NFTS      = 8'hFF
) (
  input  logic                   Pclk,
  input  logic                   Reset,
  input  logic [2:0]             OSType,
  input  logic [1:0]             LaneNumber,
  input  logic [7:0]             LinkNumber,
  input  logic [2:0]             Rate,
  input  logic                   Loopback,
  input  logic                   OSGeneratorStart,
  output logic                   OSGeneratorBusy,
  output logic                   OSGeneratorFinish,
  output logic [PIPEWIDTH-1:0]   OSData,
  output logic [PIPEWIDTH/8-1:0] OSDataK,
  output logic                   OSValid
);
  localparam int SPB = PIPEWIDTH / 8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [2:0] OS_SKP    = 3'd2;
  localparam logic [2:0] OS_EIOS   = 3'd3;
  localparam logic [2:0] OS_LEGAL  = 3'd4;

  localparam logic [3:0] LONG_LAST  = 4'(16 / SPB - 1);
  localparam logic [3:0] SHORT_LAST = 4'(4 / SPB - 1);

  logic [0:0] stateQ;
  logic [3:0] beatQ;
  logic [2:0] typeQ;
  logic [1:0] laneQ;
  logic [7:0] linkQ;
  logic [2:0] rateQ;
  logic       loopQ;

  logic       sending;
  logic       accept;
  logic       lastHit;
  logic [3:0] lastBeat;
  logic [2:0] rateEff;
  logic [7:0] rateId;

  assign sending = (stateQ == SEND);
  assign accept  = (stateQ == IDLE) && OSGeneratorStart && (OSType <= OS_LEGAL);

  always_comb begin
    lastBeat = LONG_LAST;
    if (typeQ == OS_SKP || typeQ == OS_EIOS) lastBeat = SHORT_LAST;
  end

  assign lastHit = sending && (beatQ == lastBeat);

  always_ff @(posedge Pclk or negedge Reset) begin
    if (!Reset) begin
      stateQ <= IDLE;
      beatQ  <= 4'd0;
      typeQ  <= 3'd0;
      laneQ  <= 2'd0;
      linkQ  <= 8'd0;
      rateQ  <= 3'd0;
      loopQ  <= 1'b0;
    end else if (accept) begin
      stateQ <= SEND;
      beatQ  <= 4'd0;
      typeQ  <= OSType;
      laneQ  <= LaneNumber;
      linkQ  <= LinkNumber;
      rateQ  <= Rate;
      loopQ  <= Loopback;
    end else if (sending) begin
      if (lastHit) begin
        stateQ <= IDLE;
        beatQ  <= 4'd0;
      end else begin
        beatQ  <= beatQ + 4'd1;
      end
    end
  end

  // Rate 0 advertises Gen1 only.
  assign rateEff = (rateQ == 3'd0) ? 3'd1 : rateQ;
  assign rateId  = {2'b0, rateEff >= 3'd5, rateEff >= 3'd4, rateEff >= 3'd3,
                    rateEff >= 3'd2, 1'b1, 1'b0};

  logic [SPB-1:0][7:0] symData;
  logic [SPB-1:0]      symK;

  for (genvar n = 0; n < SPB; n++) begin : gSym
    logic [3:0] symIdx;
    assign symIdx = 4'(int'(beatQ) * SPB + n);

    osSymbolEncoder #(.NFTS(NFTS)) uEnc (
      .active    (sending),
      .osType    (typeQ),
      .symIdx    (symIdx),
      .linkNumber(linkQ),
      .laneNumber(laneQ),
      .rateId    (rateId),
      .loopback  (loopQ),
      .symData   (symData[n]),
      .symK      (symK[n])
    );
  end

  assign OSData            = symData;
  assign OSDataK           = symK;
  assign OSValid           = sending;
  assign OSGeneratorBusy   = sending;
  assign OSGeneratorFinish = lastHit;
endmodule

// File: tb/tb_os_generator.sv
// Directed bench for os_generator at PIPEWIDTH 8, 16 and 32 with hand-computed beats.

module tb_os_generator;
  logic        Pclk;
  logic        Reset;
  logic [2:0]  OSType;
  logic [1:0]  LaneNumber;
  logic [7:0]  LinkNumber;
  logic [2:0]  Rate;
  logic        Loopback;
  logic        start8, start16, start32;
  logic        busy8, busy16, busy32;
  logic        fin8, fin16, fin32;
  logic        vld8, vld16, vld32;
  logic [7:0]  data8;
  logic [15:0] data16;
  logic [31:0] data32;
  logic [0:0]  k8;
  logic [1:0]  k16;
  logic [3:0]  k32;

  int pass  = 0;
  int total = 0;

  os_generator #(.PIPEWIDTH(8)) dut8 (
    .Pclk(Pclk), .Reset(Reset), .OSType(OSType), .LaneNumber(LaneNumber),
    .LinkNumber(LinkNumber), .Rate(Rate), .Loopback(Loopback),
    .OSGeneratorStart(start8), .OSGeneratorBusy(busy8), .OSGeneratorFinish(fin8),
    .OSData(data8), .OSDataK(k8), .OSValid(vld8));

  os_generator #(.PIPEWIDTH(16)) dut16 (
    .Pclk(Pclk), .Reset(Reset), .OSType(OSType), .LaneNumber(LaneNumber),
    .LinkNumber(LinkNumber), .Rate(Rate), .Loopback(Loopback),
    .OSGeneratorStart(start16), .OSGeneratorBusy(busy16), .OSGeneratorFinish(fin16),
    .OSData(data16), .OSDataK(k16), .OSValid(vld16));

  os_generator #(.PIPEWIDTH(32)) dut32 (
    .Pclk(Pclk), .Reset(Reset), .OSType(OSType), .LaneNumber(LaneNumber),
    .LinkNumber(LinkNumber), .Rate(Rate), .Loopback(Loopback),
    .OSGeneratorStart(start32), .OSGeneratorBusy(busy32), .OSGeneratorFinish(fin32),
    .OSData(data32), .OSDataK(k32), .OSValid(vld32));

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  task automatic setFields(input logic [2:0] t, input logic [7:0] link, input logic [1:0] lane,
                           input logic [2:0] r, input logic lb);
    OSType = t; LinkNumber = link; LaneNumber = lane; Rate = r; Loopback = lb;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({busy8, fin8, vld8, data8, k8} !== '0 || {busy16, fin16, vld16, data16, k16} !== '0 ||
        {busy32, fin32, vld32, data32, k32} !== '0)
      $display("FAIL reset_state got %h/%h/%h want 0", {busy8, fin8, vld8, data8, k8},
               {busy16, fin16, vld16, data16, k16}, {busy32, fin32, vld32, data32, k32});
    else pass++;
    tick();
    Reset = 1'b1;
    tick();
  endtask

  // TS1 on 8-bit pipe; optionally change LinkNumber and pulse Start mid-set.
  task automatic run_ts8(input logic [7:0] fill, input bit disturb, input string name);
    logic [7:0] expD [16];
    expD = '{8'hBC, 8'h01, 8'h01, 8'hFF, 8'h0E, 8'h04, fill, fill,
             fill, fill, fill, fill, fill, fill, fill, fill};
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (data8 !== expD[i] || k8 !== 1'(i == 0) || vld8 !== 1'b1 || busy8 !== 1'b1)
        $display("FAIL %s beat%0d got d=%h k=%b v=%b b=%b want d=%h k=%b v=1 b=1",
                 name, i, data8, k8, vld8, busy8, expD[i], 1'(i == 0));
      else pass++;
      total++;
      if (fin8 !== 1'(i == 15))
        $display("FAIL %s finish beat%0d got %b want %b", name, i, fin8, 1'(i == 15));
      else pass++;
      if (disturb && i == 0) begin LinkNumber = 8'h05; start8 = 1'b1; end
      if (disturb && i == 1) start8 = 1'b0;
      if (disturb && i == 8) start8 = 1'b1;
      if (disturb && i == 9) start8 = 1'b0;
      tick();
    end
    for (int j = 0; j < 2; j++) begin
      total++;
      if (busy8 !== 1'b0 || vld8 !== 1'b0 || fin8 !== 1'b0 || data8 !== 8'h00)
        $display("FAIL %s post_idle%0d got b=%b v=%b f=%b d=%h want 0", name, j, busy8, vld8, fin8, data8);
      else pass++;
      tick();
    end
  endtask

  task automatic test_ts1_pw8();
    setFields(3'd0, 8'h01, 2'd1, 3'd3, 1'b1);
    run_ts8(8'h4A, 1'b0, "ts1_pw8");
  endtask

  task automatic test_link_change();
    setFields(3'd0, 8'h01, 2'd1, 3'd3, 1'b1);
    run_ts8(8'h4A, 1'b1, "link_change");
  endtask

  task automatic test_eios_pw32();
    setFields(3'd3, 8'h01, 2'd1, 3'd3, 1'b1);
    start32 = 1'b1;
    tick();
    start32 = 1'b0;
    total++;
    if (data32 !== 32'h7C7C7CBC || k32 !== 4'b1111 || busy32 !== 1'b1 || fin32 !== 1'b1 || vld32 !== 1'b1)
      $display("FAIL eios_pw32 got d=%h k=%b b=%b f=%b v=%b want 7c7c7cbc 1111 1 1 1",
               data32, k32, busy32, fin32, vld32);
    else pass++;
    tick();
    total++;
    if (busy32 !== 1'b0 || fin32 !== 1'b0)
      $display("FAIL eios_pw32_after got b=%b f=%b want 0 0", busy32, fin32);
    else pass++;
  endtask

  task automatic test_ts_pw32_rate();
    logic [31:0] expD [2][4];
    logic [7:0]  links [2];
    logic [1:0]  lanes [2];
    logic [2:0]  rates [2];
    logic        lbs   [2];
    expD  = '{'{32'hFF0101BC, 32'h4A4A0402, 32'h4A4A4A4A, 32'h4A4A4A4A},
              '{32'hFF02A5BC, 32'h4A4A003E, 32'h4A4A4A4A, 32'h4A4A4A4A}};
    links = '{8'h01, 8'hA5};
    lanes = '{2'd1, 2'd2};
    rates = '{3'd0, 3'd5};
    lbs   = '{1'b1, 1'b0};
    for (int s = 0; s < 2; s++) begin
      setFields(3'd0, links[s], lanes[s], rates[s], lbs[s]);
      start32 = 1'b1;
      tick();
      start32 = 1'b0;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (data32 !== expD[s][i] || k32 !== ((i == 0) ? 4'b0001 : 4'b0000) || fin32 !== 1'(i == 3))
          $display("FAIL ts_pw32_rate%0d beat%0d got d=%h k=%b f=%b want d=%h", s, i, data32, k32, fin32, expD[s][i]);
        else pass++;
        tick();
      end
    end
  endtask

  task automatic test_idle_pw32();
    setFields(3'd4, 8'h01, 2'd1, 3'd3, 1'b1);
    start32 = 1'b1;
    tick();
    start32 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (data32 !== 32'h0 || k32 !== 4'b0 || vld32 !== 1'b1 || fin32 !== 1'(i == 3))
        $display("FAIL idle_pw32 beat%0d got d=%h k=%b v=%b f=%b", i, data32, k32, vld32, fin32);
      else pass++;
      tick();
    end
  endtask

  task automatic test_skp_pw16();
    setFields(3'd2, 8'h01, 2'd1, 3'd3, 1'b1);
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (data16 !== ((i == 0) ? 16'h1CBC : 16'h1C1C) || k16 !== 2'b11 || fin16 !== 1'(i == 1))
        $display("FAIL skp_pw16 beat%0d got d=%h k=%b f=%b", i, data16, k16, fin16);
      else pass++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] expD [8];
    int n;
    expD = '{16'h01BC, 16'hFF01, 16'h040E, 16'h4545, 16'h4545, 16'h4545, 16'h4545, 16'h4545};
    setFields(3'd1, 8'h01, 2'd1, 3'd3, 1'b1);
    start16 = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (data16 !== expD[i] || k16 !== ((i == 0) ? 2'b01 : 2'b00) || busy16 !== 1'b1 || fin16 !== 1'(i == 7))
        $display("FAIL b2b beat%0d got d=%h k=%b b=%b f=%b want d=%h", i, data16, k16, busy16, fin16, expD[i]);
      else pass++;
      tick();
    end
    total++;
    if (busy16 !== 1'b0 || vld16 !== 1'b0 || data16 !== 16'h0)
      $display("FAIL b2b_gap got b=%b v=%b d=%h want 0 0 0", busy16, vld16, data16);
    else pass++;
    tick();
    total++;
    if (busy16 !== 1'b1 || data16 !== 16'h01BC || k16 !== 2'b01)
      $display("FAIL b2b_restart got b=%b d=%h k=%b want 1 01bc 01", busy16, data16, k16);
    else pass++;
    start16 = 1'b0;
    n = 0;
    while (busy16 === 1'b1 && n < 20) begin tick(); n++; end
    total++;
    if (n !== 8)
      $display("FAIL b2b_second_len got %0d cycles want 8", n);
    else pass++;
  endtask

  task automatic test_reset_midset();
    logic [7:0] expD [16];
    setFields(3'd0, 8'h01, 2'd1, 3'd3, 1'b1);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (data8 !== 8'h4A || busy8 !== 1'b1)
      $display("FAIL rst_beat7_pre got d=%h b=%b want 4a 1", data8, busy8);
    else pass++;
    #2 Reset = 1'b0;
    #1;
    total++;
    if (busy8 !== 1'b0 || fin8 !== 1'b0 || vld8 !== 1'b0 || data8 !== 8'h00 || k8 !== 1'b0)
      $display("FAIL rst_async got b=%b f=%b v=%b d=%h k=%b want 0", busy8, fin8, vld8, data8, k8);
    else pass++;
    for (int j = 0; j < 3; j++) begin
      tick();
      total++;
      if (fin8 !== 1'b0 || busy8 !== 1'b0)
        $display("FAIL rst_hold%0d got f=%b b=%b want 0 0", j, fin8, busy8);
      else pass++;
    end
    Reset = 1'b1;
    tick();
    setFields(3'd1, 8'h01, 2'd1, 3'd3, 1'b1);
    expD = '{8'hBC, 8'h01, 8'h01, 8'hFF, 8'h0E, 8'h04, 8'h45, 8'h45,
             8'h45, 8'h45, 8'h45, 8'h45, 8'h45, 8'h45, 8'h45, 8'h45};
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (data8 !== expD[i] || k8 !== 1'(i == 0) || fin8 !== 1'(i == 15))
        $display("FAIL rst_ts2 beat%0d got d=%h k=%b f=%b want d=%h", i, data8, k8, fin8, expD[i]);
      else pass++;
      tick();
    end
  endtask

  task automatic test_illegal_type();
    setFields(3'd7, 8'h01, 2'd1, 3'd3, 1'b1);
    start8 = 1'b1; start16 = 1'b1; start32 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      total++;
      if ({busy8, vld8, fin8, busy16, vld16, fin16, busy32, vld32, fin32} !== 9'b0)
        $display("FAIL illegal_type cyc%0d got %b want 0", j,
                 {busy8, vld8, fin8, busy16, vld16, fin16, busy32, vld32, fin32});
      else pass++;
    end
    start8 = 1'b0; start16 = 1'b0; start32 = 1'b0;
    tick();
  endtask

  initial begin
    Reset = 1'b0;
    start8 = 1'b0; start16 = 1'b0; start32 = 1'b0;
    setFields(3'd0, 8'h00, 2'd0, 3'd0, 1'b0);
    test_reset();
    test_ts1_pw8();
    test_link_change();
    test_eios_pw32();
    test_ts_pw32_rate();
    test_idle_pw32();
    test_skp_pw16();
    test_back_to_back();
    test_reset_midset();
    test_illegal_type();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
